// File: rtl/regfile_np_if.sv
// Register-file access bundle: packed read ports, single write port and status.
// The datapath drives it as master; regfile_np is the slave.
interface regfile_np_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) ();
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic                     ready;
  logic                     wr_lost;

  modport master (
    output rd_addr, RegWrite, write_reg, write_data,
    input  rd_data, ready, wr_lost
  );

  modport slave (
    input  rd_addr, RegWrite, write_reg, write_data,
    output rd_data, ready, wr_lost
  );
endinterface

// File: rtl/regfile_np.sv
// Multi-read-port register file with r0 hardwired to zero and a post-reset scrub.
// Define REGFILE_BYPASS_EN to forward the in-flight write to matching read ports.
module regfile_np #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_np_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StScrub, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   scrub_cnt_q;
  logic                ready_q;
  logic                wr_lost_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                      wr_en;
  logic [ADDR_W-1:0]         rd_a;
  logic [NUM_RD*DATA_W-1:0]  rd_data_c;

  assign wr_en = ready_q && bus.RegWrite && (bus.write_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StScrub;
      scrub_cnt_q <= '0;
      ready_q     <= 1'b0;
      wr_lost_q   <= 1'b0;
    end else begin
      // Any write attempt before the scrub finishes is dropped, r0 included.
      if (bus.RegWrite && !ready_q) begin
        wr_lost_q <= 1'b1;
      end
      case (state_q)
        StScrub: begin
          scrub_cnt_q <= scrub_cnt_q + ADDR_W'(1);
          if (&scrub_cnt_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StScrub;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; the scrub zeroes it one entry per edge instead.
  always_ff @(posedge clk) begin
    if (state_q == StScrub) begin
      mem_q[scrub_cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[bus.write_reg] <= bus.write_data;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_a      = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (rd_a == '0) begin
        rd_data_c[i*DATA_W +: DATA_W] = '0;
      end else if (!ready_q) begin
        rd_data_c[i*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_en && (bus.write_reg == rd_a)) begin
        rd_data_c[i*DATA_W +: DATA_W] = bus.write_data;
`endif
      end else begin
        rd_data_c[i*DATA_W +: DATA_W] = mem_q[rd_a];
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.ready   = ready_q;
  assign bus.wr_lost = wr_lost_q;

endmodule

// File: tb/tb_regfile_np.sv
// Randomized bench for regfile_np against a behavioural model of the register file.
module tb_regfile_np;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_np_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: contents are meaningless until DEPTH edges after release, then all zero.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_edges;
  bit            m_ready;
  bit            m_lost;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!m_ready) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && bus.write_reg != 0 && bus.write_reg == a) return bus.write_data;
`endif
    return m_mem[a];
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_ready = 1'b0;
    m_lost  = 1'b0;
  endtask

  task automatic model_update();
    if (!m_ready) begin
      if (bus.RegWrite) m_lost = 1'b1;
      m_edges++;
      if (m_edges == DEPTH) begin
        m_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      end
    end else if (bus.RegWrite && bus.write_reg != 0) begin
      m_mem[bus.write_reg] = bus.write_data;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [AW-1:0] a;
    check({tag, " ready"}, DW'(bus.ready), DW'(m_ready));
    check({tag, " wr_lost"}, DW'(bus.wr_lost), DW'(m_lost));
    for (int i = 0; i < NR; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      check($sformatf("%s rd%0d a%0d", tag, i, a), bus.rd_data[i*DW +: DW], exp_read(a));
    end
  endtask

  task automatic set_in(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.RegWrite   = we;
    bus.write_reg  = wa;
    bus.write_data = wd;
    bus.rd_addr    = {a1, a0};
  endtask

  // Check combinational outputs mid-cycle, then advance the model across the edge.
  task automatic tick(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic random_phase(input int n);
    logic [AW-1:0] wa;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    for (int t = 0; t < n; t++) begin
      wa = raddr();
      a0 = ($urandom_range(0, 3) == 0) ? wa : raddr();
      a1 = ($urandom_range(0, 3) == 0) ? wa : raddr();
      set_in(($urandom_range(0, 1) == 1), wa, $urandom(), a0, a1);
      tick("rand");
    end
  endtask

  task automatic scrub_phase(input string tag, input int early_idx);
    for (int t = 0; t < DEPTH; t++) begin
      if (t == early_idx) set_in(1'b1, 5'd5, 32'h0000_1234, raddr(), raddr());
      else set_in(1'b0, raddr(), $urandom(), raddr(), raddr());
      tick(tag);
    end
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_in(1'b0, '0, '0, AW'(a), AW'(a + 1));
      tick(tag);
    end
  endtask

  initial begin
    set_in(1'b0, '0, '0, '0, '0);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("in_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Scrub with a write on the 10th cycle, which must be lost.
    scrub_phase("scrub", 9);
    check("early wr_lost", DW'(bus.wr_lost), DW'(1));
    check("ready after scrub", DW'(bus.ready), DW'(1));
    read_all("post_scrub");

    set_in(1'b1, 5'd3, 32'hABCD_EF12, 5'd3, 5'd1);
    tick("wr_r3");
    set_in(1'b0, '0, '0, 5'd3, 5'd1);
    #1;
    check("r3 readback", bus.rd_data[DW-1:0], 32'hABCD_EF12);
    tick("rd_r3");

    set_in(1'b1, 5'd7, 32'h55AA_55AA, 5'd0, 5'd7);
    tick("bypass_pre");
    set_in(1'b0, '0, '0, 5'd0, 5'd7);
    tick("bypass_post");

    random_phase(300);

    for (int r = 1; r < DEPTH; r++) begin
      set_in(1'b1, AW'(r), DW'(r), AW'(r), AW'(r - 1));
      tick("fill");
    end

    // Mid-run async reset: ready must drop without waiting for an edge.
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("midrun_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    scrub_phase("rescrub", -1);
    read_all("post_rescrub");

    set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    tick("wr_r0");
    set_in(1'b0, '0, '0, 5'd0, 5'd0);
    tick("rd_r0");
    check("r0 wr_lost", DW'(bus.wr_lost), DW'(0));

    random_phase(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised multi-read-port register file for the pipelined MIPS datapath, successor to the fixed 32x32 two-port file. It provides NUM_RD combinational read ports and one clocked write port, and hardwires register 0 to zero. After reset it runs a scrub sequence that zeroes every entry, so simulation and silicon never read X. Optional same-cycle write-to-read bypass removes the need for a decode-stage forwarding mux.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
- RegWrite  input  1  write enable
- write_reg  input  ADDR_W  write address
- write_data  input  DATA_W  write data
- ready  output  1  high once the scrub is complete; the file is accepting writes
- wr_lost  output  1  sticky flag; set when a write is requested while ready=0

## Operation
- FSM states: SCRUB and RUN.
- Reset asserted (async): state=SCRUB, scrub counter=0, ready=0, wr_lost=0. Array contents are not touched asynchronously.
- SCRUB:
  - Each rising edge writes 0 to entry[counter], then increments the counter.
  - When counter == DEPTH-1 is written, go to RUN on that edge. The counter wraps to 0 and does not overflow.
- RUN:
  - If RegWrite=1 and write_reg != 0, entry[write_reg] <= write_data on the rising edge.
  - A write to address 0 is silently discarded and does not set wr_lost.
- Reads are combinational: rd_data[i] = entry[rd_addr[i]].
  - rd_addr[i]==0 always returns 0.
  - While ready=0, every port returns 0, regardless of the partially scrubbed contents.
- Write while ready=0 (RegWrite=1, any address including 0): the write is dropped and wr_lost is set to 1 on that edge. wr_lost stays set until the next rst_n assertion.
- Multiple ports may read the same address in the same cycle; each returns the identical value.
- Reset asserted mid-RUN or mid-SCRUB: ready drops immediately (async). A full scrub restarts from address 0 after release, and the previous contents are lost.

## Timing
- Scrub latency: ready rises DEPTH rising edges after rst_n deasserts (32 edges at default).
- Write latency:
  - Without the bypass, a value written at edge N is visible on rd_data from just after edge N.
  - During the cycle before edge N, reads of that address return the old value.
- Read path: purely combinational from rd_addr, the array, and, when bypass is enabled, the write port. No registered outputs.
- Reset values: ready=0, wr_lost=0, rd_data=0 on all ports.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When ready=1, RegWrite=1, write_reg != 0 and rd_addr[i]==write_reg, rd_data[i] = write_data in the same cycle.
  - This gives write-before-read semantics for the MIPS first-half-write / second-half-read convention.
- REGFILE_BYPASS_EN undefined: no forwarding; rd_data[i] always reflects the stored array contents.
- Priority, both builds: address 0 -> 0 first, then ready=0 -> 0, then bypass (when compiled in), then array.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles and release -> ready=0 for exactly 32 edges, then 1; every rd_data reads 0 for all 32 addresses.
- Basic write/read: after ready, write 0xABCDEF12 to r3 -> from the next cycle rd_data port0 (addr 3) = 0xABCDEF12, and port1 (addr 1) = 0.
- Zero register: write 0xFFFFFFFF to r0 -> reads of r0 return 0 and wr_lost stays 0.
- Early write: assert RegWrite to r5 with 0x1234 during the 10th scrub cycle -> wr_lost=1; after ready, r5 reads 0.
- Bypass: with RegWrite=1, write_reg=7, write_data=0x55AA55AA and rd_addr port1=7 in the same cycle:
  - REGFILE_BYPASS_EN defined -> port1 = 0x55AA55AA before the edge.
  - REGFILE_BYPASS_EN undefined -> port1 shows the old value (0) before the edge and 0x55AA55AA after it.
- Reset mid-run: fill r1..r31 with their index and pulse rst_n low for 1 cycle -> ready=0, wr_lost=0; after 32 edges every register reads 0.
